// File: rtl/tlul_pkg.sv
// TL-UL bus types, opcodes and sizing helpers shared by the
// 1:N socket and its error responder.
package tlul_pkg;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int SrcW = 8;
    localparam int SzW = 2;

    localparam int MaxOutstandingDefault = 8;

    typedef enum logic [2:0] {
        PutFullData    = 3'h0,
        PutPartialData = 3'h1,
        Get            = 3'h4
    } tl_a_op_e;

    typedef enum logic [2:0] {
        AccessAck     = 3'h0,
        AccessAckData = 3'h1
    } tl_d_op_e;

    typedef enum logic {
        ERR_IDLE,
        ERR_RESP
    } err_state_e;

    typedef struct packed {
        logic            a_valid;
        tl_a_op_e        a_opcode;
        logic [2:0]      a_param;
        logic [SzW-1:0]  a_size;
        logic [SrcW-1:0] a_source;
        logic [AW-1:0]   a_address;
        logic [DW/8-1:0] a_mask;
        logic [DW-1:0]   a_data;
        logic            d_ready;
    } tl_h2d_t;

    typedef struct packed {
        logic            d_valid;
        tl_d_op_e        d_opcode;
        logic [2:0]      d_param;
        logic [SzW-1:0]  d_size;
        logic [SrcW-1:0] d_source;
        logic            d_sink;
        logic [DW-1:0]   d_data;
        logic            d_error;
        logic            a_ready;
    } tl_d2h_t;

    // Select width leaves one code above N-1 for the error responder.
    function automatic int sel_w(int n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/tlul_err_resp_1d.sv
// Single-entry error responder: answers any request with d_error
// set, echoing source and size, one request at a time.
module tlul_err_resp_1d
    import tlul_pkg::*;
(
    input  logic    clk_i,
    input  logic    rst_i,
    input  tl_h2d_t tl_h_i,
    output tl_d2h_t tl_h_o
);

    err_state_e      state_q;
    err_state_e      state_d;
    logic [SrcW-1:0] src_q;
    logic [SzW-1:0]  size_q;
    tl_a_op_e        op_q;
    logic            accept;

    logic unused_a;
    assign unused_a = ^{tl_h_i.a_param, tl_h_i.a_address,
                        tl_h_i.a_mask, tl_h_i.a_data};

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= ERR_IDLE;
            src_q   <= '0;
            size_q  <= '0;
            op_q    <= PutFullData;
        end else begin
            state_q <= state_d;
            if (accept) begin
                src_q  <= tl_h_i.a_source;
                size_q <= tl_h_i.a_size;
                op_q   <= tl_h_i.a_opcode;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        tl_h_o  = '0;
        accept  = 1'b0;
        unique case (state_q)
            ERR_IDLE: begin
                tl_h_o.a_ready = 1'b1;
                accept = tl_h_i.a_valid;
                if (accept) state_d = ERR_RESP;
            end
            ERR_RESP: begin
                tl_h_o.d_valid  = 1'b1;
                tl_h_o.d_error  = 1'b1;
                tl_h_o.d_source = src_q;
                tl_h_o.d_size   = size_q;
                tl_h_o.d_data   = '1;
                tl_h_o.d_opcode = (op_q == Get) ? AccessAckData
                                                : AccessAck;
                if (tl_h_i.d_ready) state_d = ERR_IDLE;
            end
        endcase
    end

endmodule

// File: rtl/tlul_socket_1n_track.sv
// 1:N TL-UL socket that counts in-flight requests and blocks a
// target switch until every response from the old target is back.
module tlul_socket_1n_track
    import tlul_pkg::*;
#(
    parameter int N = 4,
    parameter int MaxOutstanding = MaxOutstandingDefault,
    localparam int SelW = sel_w(N)
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  tl_h2d_t         tl_h_i,
    output tl_d2h_t         tl_h_o,
    input  logic [SelW-1:0] dev_select_i,
    output tl_h2d_t         tl_d_o [N],
    input  tl_d2h_t         tl_d_i [N]
);

    localparam int CntW = $clog2(MaxOutstanding + 1);
    localparam logic [CntW-1:0] CntMax = CntW'(MaxOutstanding);

    logic [CntW-1:0] out_cnt;
    logic [SelW-1:0] out_sel;
    logic            hold;
    logic            accept;
    logic            complete;
    logic            sel_err;
    logic            rsp_err;
    logic            a_ready_mux;
    tl_d2h_t         rsp_mux;
    tl_h2d_t         err_req;
    tl_d2h_t         err_rsp;

    assign sel_err = dev_select_i >= SelW'(N);
    assign rsp_err = out_sel >= SelW'(N);

    // Hold reads the registered count, so a completion draining the
    // last entry only frees the switch on the following cycle.
    assign hold = (out_cnt != '0 && dev_select_i != out_sel)
               || (out_cnt == CntMax);

    always_comb begin
        a_ready_mux = err_rsp.a_ready;
        rsp_mux     = err_rsp;
        for (int k = 0; k < N; k++) begin
            if (dev_select_i == SelW'(k)) a_ready_mux = tl_d_i[k].a_ready;
            if (out_sel == SelW'(k))      rsp_mux = tl_d_i[k];
        end
    end

    always_comb begin
        tl_h_o         = rsp_mux;
        tl_h_o.a_ready = a_ready_mux && !hold && !rst_i;
        tl_h_o.d_valid = rsp_mux.d_valid && !rst_i;
    end

    always_comb begin
        for (int k = 0; k < N; k++) begin
            tl_d_o[k]         = tl_h_i;
            tl_d_o[k].a_valid = tl_h_i.a_valid && !hold && !rst_i
                             && dev_select_i == SelW'(k);
            tl_d_o[k].d_ready = tl_h_i.d_ready && !rst_i
                             && out_sel == SelW'(k);
        end
    end

    always_comb begin
        err_req         = tl_h_i;
        err_req.a_valid = tl_h_i.a_valid && sel_err && !hold && !rst_i;
        err_req.d_ready = tl_h_i.d_ready && rsp_err && !rst_i;
    end

    tlul_err_resp_1d u_err (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .tl_h_i (err_req),
        .tl_h_o (err_rsp)
    );

    assign accept   = tl_h_i.a_valid && tl_h_o.a_ready;
    assign complete = tl_h_o.d_valid && tl_h_i.d_ready;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            out_cnt <= '0;
            out_sel <= '0;
        end else begin
            if (accept && !complete)      out_cnt <= out_cnt + CntW'(1);
            else if (complete && !accept) out_cnt <= out_cnt - CntW'(1);
            if (accept) out_sel <= dev_select_i;
        end
    end

    a_no_underflow: assert property (@(posedge clk_i) disable iff (rst_i)
        !(complete && out_cnt == '0));

    a_no_overflow: assert property (@(posedge clk_i) disable iff (rst_i)
        !(accept && !complete && out_cnt == CntMax));

endmodule
